// File: rtl/axi_burst_master.sv
// AXI4 single-burst master: turns a command + data stream into one INCR burst on AW/W/B or AR/R.
// Latency: address valid is registered one cycle after command accept; W/R beats pass through combinationally.
// Backpressure: one transaction in flight; cmd_ready is low until the completion is acknowledged.
// Optional macro AXI_MASTER_4K_CHECK_EN: reject commands whose burst would cross a 4KB boundary.
module axi_burst_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MASTER_ID  = 0
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  // command interface
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  // user write stream
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  // user read stream
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  // completion
  output logic                    done_valid,
  input  logic                    done_ready,
  output logic [1:0]              done_resp,
  // AXI write address channel
  output logic [ID_WIDTH-1:0]     M_AXI_awid,
  output logic [ADDR_WIDTH-1:0]   M_AXI_awaddr,
  output logic [7:0]              M_AXI_awlen,
  output logic [2:0]              M_AXI_awsize,
  output logic [1:0]              M_AXI_awburst,
  output logic [1:0]              M_AXI_awlock,
  output logic [3:0]              M_AXI_awcache,
  output logic [2:0]              M_AXI_awprot,
  output logic [3:0]              M_AXI_awqos,
  output logic [3:0]              M_AXI_awregion,
  output logic                    M_AXI_awvalid,
  input  logic                    M_AXI_awready,
  // AXI write data channel
  output logic [DATA_WIDTH-1:0]   M_AXI_wdata,
  output logic [DATA_WIDTH/8-1:0] M_AXI_wstrb,
  output logic                    M_AXI_wlast,
  output logic                    M_AXI_wvalid,
  input  logic                    M_AXI_wready,
  // AXI write response channel
  input  logic [ID_WIDTH-1:0]     M_AXI_bid,
  input  logic [1:0]              M_AXI_bresp,
  input  logic                    M_AXI_bvalid,
  output logic                    M_AXI_bready,
  // AXI read address channel
  output logic [ID_WIDTH-1:0]     M_AXI_arid,
  output logic [ADDR_WIDTH-1:0]   M_AXI_araddr,
  output logic [7:0]              M_AXI_arlen,
  output logic [2:0]              M_AXI_arsize,
  output logic [1:0]              M_AXI_arburst,
  output logic [1:0]              M_AXI_arlock,
  output logic [3:0]              M_AXI_arcache,
  output logic [2:0]              M_AXI_arprot,
  output logic [3:0]              M_AXI_arqos,
  output logic [3:0]              M_AXI_arregion,
  output logic                    M_AXI_arvalid,
  input  logic                    M_AXI_arready,
  // AXI read data channel
  input  logic [ID_WIDTH-1:0]     M_AXI_rid,
  input  logic [DATA_WIDTH-1:0]   M_AXI_rdata,
  input  logic [1:0]              M_AXI_rresp,
  input  logic                    M_AXI_rlast,
  input  logic                    M_AXI_rvalid,
  output logic                    M_AXI_rready
);

  localparam int                  STRB_W = DATA_WIDTH / 8;
  localparam logic [2:0]          SIZE   = 3'($clog2(STRB_W));
  localparam logic [ID_WIDTH-1:0] MID    = ID_WIDTH'(MASTER_ID);

  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [7:0]              beat_cnt;
  logic [1:0]              resp_q;
  logic                    err_q;

  logic                    last_beat;
  logic                    w_hs;
  logic                    r_hs;
  logic [1:0]              r_resp_max;
  logic                    r_err_next;
  logic [1:0]              b_resp;
  logic                    cross_4k;

  // Read ID is not checked; only B carries an ID check.
  logic                    unused_rid;
  assign unused_rid = ^M_AXI_rid;

  // Constant AXI attributes
  assign M_AXI_awid     = MID;
  assign M_AXI_arid     = MID;
  assign M_AXI_awsize   = SIZE;
  assign M_AXI_arsize   = SIZE;
  assign M_AXI_awburst  = 2'b01;
  assign M_AXI_arburst  = 2'b01;
  assign M_AXI_awlock   = 2'b00;
  assign M_AXI_arlock   = 2'b00;
  assign M_AXI_awcache  = 4'h0;
  assign M_AXI_arcache  = 4'h0;
  assign M_AXI_awprot   = 3'b000;
  assign M_AXI_arprot   = 3'b000;
  assign M_AXI_awqos    = 4'h0;
  assign M_AXI_arqos    = 4'h0;
  assign M_AXI_awregion = 4'h0;
  assign M_AXI_arregion = 4'h0;

  assign M_AXI_awaddr = addr_q;
  assign M_AXI_araddr = addr_q;
  assign M_AXI_awlen  = len_q;
  assign M_AXI_arlen  = len_q;

  // Burst end is decided by our own beat count, never by the slave's rlast.
  assign last_beat = (beat_cnt == len_q);

  // Write data path: user stream straight onto W while in W state
  assign M_AXI_wvalid = (state == W) && wr_valid;
  assign wr_ready     = (state == W) && M_AXI_wready;
  assign M_AXI_wdata  = wr_data;
  assign M_AXI_wstrb  = wr_strb;
  assign M_AXI_wlast  = (state == W) && last_beat;
  assign w_hs         = (state == W) && wr_valid && M_AXI_wready;

  // Read data path: R channel straight onto the user stream while in R state
  assign rd_valid      = (state == R) && M_AXI_rvalid;
  assign M_AXI_rready  = (state == R) && rd_ready;
  assign rd_data       = M_AXI_rdata;
  assign rd_last       = (state == R) && last_beat;
  assign r_hs          = (state == R) && M_AXI_rvalid && rd_ready;

  // Worst response seen so far, and a sticky flag for rlast disagreeing with our count
  assign r_resp_max = (M_AXI_rresp > resp_q) ? M_AXI_rresp : resp_q;
  assign r_err_next = err_q | (M_AXI_rlast != last_beat);
  // A B response carrying someone else's ID is reported as SLVERR
  assign b_resp     = (M_AXI_bid != MID) ? 2'b10 : M_AXI_bresp;

`ifdef AXI_MASTER_4K_CHECK_EN
  logic [31:0] end_off;
  // Offset of the first byte past the burst, relative to its 4KB page
  assign end_off  = 32'(cmd_addr[11:0]) + (32'(cmd_len) + 32'd1) * 32'(STRB_W);
  assign cross_4k = (end_off > 32'd4096);
`else
  assign cross_4k = 1'b0;
`endif

  // Transaction FSM with registered handshake outputs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      beat_cnt      <= '0;
      resp_q        <= 2'b00;
      err_q         <= 1'b0;
      cmd_ready     <= 1'b0;
      M_AXI_awvalid <= 1'b0;
      M_AXI_arvalid <= 1'b0;
      M_AXI_bready  <= 1'b0;
      done_valid    <= 1'b0;
      done_resp     <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_ready && cmd_valid) begin
            addr_q    <= cmd_addr;
            len_q     <= cmd_len;
            beat_cnt  <= '0;
            resp_q    <= 2'b00;
            err_q     <= 1'b0;
            cmd_ready <= 1'b0;
            if (cross_4k) begin
              done_valid <= 1'b1;
              done_resp  <= 2'b10;
              state      <= DONE;
            end else if (cmd_write) begin
              M_AXI_awvalid <= 1'b1;
              state         <= AW;
            end else begin
              M_AXI_arvalid <= 1'b1;
              state         <= AR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        AW: begin
          if (M_AXI_awready) begin
            M_AXI_awvalid <= 1'b0;
            state         <= W;
          end
        end
        W: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (last_beat) begin
              M_AXI_bready <= 1'b1;
              state        <= B;
            end
          end
        end
        B: begin
          if (M_AXI_bvalid) begin
            M_AXI_bready <= 1'b0;
            done_valid   <= 1'b1;
            done_resp    <= b_resp;
            state        <= DONE;
          end
        end
        AR: begin
          if (M_AXI_arready) begin
            M_AXI_arvalid <= 1'b0;
            state         <= R;
          end
        end
        R: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            resp_q   <= r_resp_max;
            err_q    <= r_err_next;
            if (last_beat) begin
              done_valid <= 1'b1;
              done_resp  <= r_err_next ? 2'b10 : r_resp_max;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          if (done_ready) begin
            done_valid <= 1'b0;
            done_resp  <= 2'b00;
            cmd_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: vector table of bursts against a word-array slave model,
// plus hand sequences for reset mid-burst and the 4KB-boundary command.
`timescale 1ns/1ps
module tb_axi_burst_master;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [31:0] cmd_addr = 0;
  logic [7:0]  cmd_len = 0;
  logic        wr_valid = 0, wr_ready;
  logic [31:0] wr_data = 0;
  logic [3:0]  wr_strb = 0;
  logic        rd_valid, rd_ready = 0, rd_last;
  logic [31:0] rd_data;
  logic        done_valid, done_ready = 0;
  logic [1:0]  done_resp;
  logic [3:0]  awid, arid, bid = 0, rid = 0;
  logic [31:0] awaddr, araddr, wdata, rdata = 0;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, awlock, arlock, bresp = 0, rresp = 0;
  logic [3:0]  awcache, arcache, awqos, arqos, awregion, arregion, wstrb;
  logic        awvalid, awready = 0, wlast, wvalid, wready = 0, bvalid = 0, bready;
  logic        arvalid, arready = 0, rlast = 0, rvalid = 0, rready;

  axi_burst_master dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done_valid(done_valid), .done_ready(done_ready), .done_resp(done_resp),
    .M_AXI_awid(awid), .M_AXI_awaddr(awaddr), .M_AXI_awlen(awlen), .M_AXI_awsize(awsize),
    .M_AXI_awburst(awburst), .M_AXI_awlock(awlock), .M_AXI_awcache(awcache),
    .M_AXI_awprot(awprot), .M_AXI_awqos(awqos), .M_AXI_awregion(awregion),
    .M_AXI_awvalid(awvalid), .M_AXI_awready(awready),
    .M_AXI_wdata(wdata), .M_AXI_wstrb(wstrb), .M_AXI_wlast(wlast),
    .M_AXI_wvalid(wvalid), .M_AXI_wready(wready),
    .M_AXI_bid(bid), .M_AXI_bresp(bresp), .M_AXI_bvalid(bvalid), .M_AXI_bready(bready),
    .M_AXI_arid(arid), .M_AXI_araddr(araddr), .M_AXI_arlen(arlen), .M_AXI_arsize(arsize),
    .M_AXI_arburst(arburst), .M_AXI_arlock(arlock), .M_AXI_arcache(arcache),
    .M_AXI_arprot(arprot), .M_AXI_arqos(arqos), .M_AXI_arregion(arregion),
    .M_AXI_arvalid(arvalid), .M_AXI_arready(arready),
    .M_AXI_rid(rid), .M_AXI_rdata(rdata), .M_AXI_rresp(rresp), .M_AXI_rlast(rlast),
    .M_AXI_rvalid(rvalid), .M_AXI_rready(rready)
  );

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] base;      // beat b carries base+b
    logic [3:0]  strb_b1;   // strobe on beat index 1, others 4'hF
    bit          stall;     // read: rd_ready toggles every cycle
    logic [1:0]  bresp;
    logic [3:0]  bid;
    int          rr_idx;    // read beat given rr_val as rresp (-1 none)
    logic [1:0]  rr_val;
    int          rlast_bad; // read beat whose rlast is inverted (-1 none)
    logic [1:0]  exp_resp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [0:2047];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tfail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " awvalid"},    awvalid, 0);
    chk({tag, " wvalid"},     wvalid, 0);
    chk({tag, " bready"},     bready, 0);
    chk({tag, " arvalid"},    arvalid, 0);
    chk({tag, " rready"},     rready, 0);
    chk({tag, " cmd_ready"},  cmd_ready, 0);
    chk({tag, " wr_ready"},   wr_ready, 0);
    chk({tag, " rd_valid"},   rd_valid, 0);
    chk({tag, " rd_last"},    rd_last, 0);
    chk({tag, " done_valid"}, done_valid, 0);
    chk({tag, " done_resp"},  done_resp, 0);
  endtask

  task automatic send_cmd(input bit wr, input logic [31:0] addr, input logic [7:0] len, output bit ok);
    int n;
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    #1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge ACLK); #1; n++; end
    ok = cmd_ready;
    if (!ok) begin tfail("cmd_ready"); cmd_valid = 0; return; end
    @(posedge ACLK);
    @(negedge ACLK);
    cmd_valid = 0;
  endtask

  task automatic addr_phase(input bit wr, input logic [31:0] addr, input logic [7:0] len, output bit ok);
    int n;
    n = 0;
    while (!(wr ? awvalid : arvalid) && n < 20) begin @(negedge ACLK); n++; end
    ok = wr ? awvalid : arvalid;
    if (!ok) begin tfail(wr ? "awvalid" : "arvalid"); return; end
    chk("addr",  wr ? awaddr : araddr, addr);
    chk("len",   wr ? awlen : arlen, len);
    chk("size",  wr ? awsize : arsize, 3'd2);
    chk("burst", wr ? awburst : arburst, 2'b01);
    chk("id",    wr ? awid : arid, 4'd0);
    @(negedge ACLK);
    chk("addr valid held", wr ? awvalid : arvalid, 1);
    if (wr) awready = 1; else arready = 1;
    @(posedge ACLK);
    @(negedge ACLK);
    awready = 0; arready = 0;
    chk("addr valid dropped", wr ? awvalid : arvalid, 0);
  endtask

  task automatic run_vec(input vec_t v);
    bit         ok, hs;
    int         i, cyc;
    logic [10:0] idx;
    send_cmd(v.write, v.addr, v.len, ok);
    if (!ok) return;
    addr_phase(v.write, v.addr, v.len, ok);
    if (!ok) return;
    idx = v.addr[12:2];
    if (v.write) begin
      for (int b = 0; b <= int'(v.len); b++) begin
        wr_valid = 1; wr_data = v.base + 32'(b); wr_strb = (b == 1) ? v.strb_b1 : 4'hF; wready = 1;
        #1;
        chk("wvalid",   wvalid, 1);
        chk("wr_ready", wr_ready, 1);
        chk("wlast",    wlast, (b == int'(v.len)));
        chk("wdata",    wdata, v.base + 32'(b));
        chk("wstrb",    wstrb, (b == 1) ? v.strb_b1 : 4'hF);
        for (int k = 0; k < 4; k++)
          if (wstrb[k]) mem[idx + 11'(b)][8*k +: 8] = wdata[8*k +: 8];
        @(posedge ACLK);
        @(negedge ACLK);
      end
      wr_valid = 0; wready = 0;
      chk("bready", bready, 1);
      bvalid = 1; bresp = v.bresp; bid = v.bid;
      @(posedge ACLK);
      @(negedge ACLK);
      bvalid = 0; bresp = 0; bid = 0;
    end else begin
      i = 0; cyc = 0;
      while (i <= int'(v.len) && cyc < 1000) begin
        rvalid = 1; rdata = mem[idx + 11'(i)];
        rresp = (i == v.rr_idx) ? v.rr_val : 2'b00;
        rlast = (i == int'(v.len)) ^ (i == v.rlast_bad);
        rd_ready = v.stall ? cyc[0] : 1'b1;
        #1;
        chk("rd_valid", rd_valid, 1);
        chk("rd_data",  rd_data, mem[idx + 11'(i)]);
        chk("rd_last",  rd_last, (i == int'(v.len)));
        chk("rready",   rready, rd_ready);
        hs = rd_ready;
        @(posedge ACLK);
        @(negedge ACLK);
        if (hs) i++;
        cyc++;
      end
      rvalid = 0; rd_ready = 0; rlast = 0; rresp = 0;
      if (i <= int'(v.len)) begin tfail("read beats"); return; end
    end
    chk("done_valid",         done_valid, 1);
    chk("done_resp",          done_resp, v.exp_resp);
    chk("cmd_ready in DONE",  cmd_ready, 0);
    done_ready = 1;
    @(posedge ACLK);
    @(negedge ACLK);
    done_ready = 0;
    chk("done_valid cleared", done_valid, 0);
  endtask

  initial begin
    vec_t vecs [9];
    vec_t v;
    bit   ok, saw_aw;
    int   n;

    vecs[0] = '{1, 32'h10,  8'd0,   32'hDEADBEEF, 4'hF, 0, 2'b00, 4'h0, -1, 2'b00, -1, 2'b00};
    vecs[1] = '{1, 32'h40,  8'd3,   32'h1,        4'h3, 0, 2'b00, 4'h0, -1, 2'b00, -1, 2'b00};
    vecs[2] = '{0, 32'h40,  8'd3,   32'h0,        4'hF, 1, 2'b00, 4'h0, -1, 2'b00, -1, 2'b00};
    vecs[3] = '{1, 32'h80,  8'd1,   32'h100,      4'hF, 0, 2'b10, 4'h0, -1, 2'b00, -1, 2'b10};
    vecs[4] = '{1, 32'h84,  8'd0,   32'h200,      4'hF, 0, 2'b00, 4'h0, -1, 2'b00, -1, 2'b00};
    vecs[5] = '{1, 32'h90,  8'd0,   32'h300,      4'hF, 0, 2'b00, 4'h3, -1, 2'b00, -1, 2'b10};
    vecs[6] = '{0, 32'h100, 8'd2,   32'h0,        4'hF, 0, 2'b00, 4'h0,  1, 2'b01, -1, 2'b01};
    vecs[7] = '{0, 32'h100, 8'd2,   32'h0,        4'hF, 0, 2'b00, 4'h0, -1, 2'b00,  1, 2'b10};
    vecs[8] = '{0, 32'h400, 8'd255, 32'h0,        4'hF, 0, 2'b00, 4'h0, -1, 2'b00, -1, 2'b00};

    for (int i = 0; i < 2048; i++) mem[i] = 32'hA5A5_0000 | 32'(i);

    // Reset state
    #12;
    chk_quiet("reset");
    @(negedge ACLK);
    ARESETN = 1;

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i]);
      if (i == 0) chk("mem word 4", mem[4], 32'hDEADBEEF);
      if (i == 1) begin
        chk("mem 0x40", mem[16], 32'h1);
        chk("mem 0x44", mem[17], 32'hA5A50002);
        chk("mem 0x48", mem[18], 32'h3);
        chk("mem 0x4C", mem[19], 32'h4);
      end
      if (i == 3) chk("mem 0x84 after err", mem[33], 32'h101);
    end

    // Reset pulsed during W beat 2
    send_cmd(1, 32'h200, 8'd3, ok);
    if (ok) addr_phase(1, 32'h200, 8'd3, ok);
    if (ok) begin
      wr_valid = 1; wr_data = 32'h11; wr_strb = 4'hF; wready = 1;
      @(posedge ACLK);
      @(negedge ACLK);
      wr_data = 32'h12;
      #1;
      chk("beat2 wvalid before reset", wvalid, 1);
      ARESETN = 0;
      #1;
      chk_quiet("mid-burst reset");
      wr_valid = 0; wready = 0;
      @(negedge ACLK);
      ARESETN = 1;
      @(negedge ACLK);
      @(negedge ACLK);
      chk("cmd_ready after reset", cmd_ready, 1);
      chk("no completion after reset", done_valid, 0);
      v = '{1, 32'h300, 8'd1, 32'hCAFE0000, 4'hF, 0, 2'b00, 4'h0, -1, 2'b00, -1, 2'b00};
      run_vec(v);
      chk("mem 0x304 after reset", mem[193], 32'hCAFE0001);
    end

    // Command crossing a 4KB page
`ifdef AXI_MASTER_4K_CHECK_EN
    send_cmd(1, 32'hFF8, 8'd3, ok);
    if (ok) begin
      saw_aw = 0; n = 0;
      while (!done_valid && n < 20) begin
        if (awvalid) saw_aw = 1;
        @(negedge ACLK); n++;
      end
      if (!done_valid) tfail("4k done_valid");
      else begin
        chk("4k no awvalid", saw_aw, 0);
        chk("4k done_resp",  done_resp, 2'b10);
        done_ready = 1;
        @(posedge ACLK);
        @(negedge ACLK);
        done_ready = 0;
        chk("4k done cleared", done_valid, 0);
      end
    end
`else
    saw_aw = 0; n = 0;
    v = '{1, 32'hFF8, 8'd3, 32'h7700, 4'hF, 0, 2'b00, 4'h0, -1, 2'b00, -1, 2'b00};
    run_vec(v);
    chk("4k burst word 0xFF8",  mem[1022], 32'h7700);
    chk("4k burst word 0x1004", mem[1025], 32'h7703);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
